// File: rtl/jpeg_pkg.sv
// Shared types and luma weights for the jpeg pixel framer.
// The luma helper uses a 16-bit accumulator; the weights sum to 256, so the top byte never overflows.
package jpeg_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } framer_state_e;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  function automatic logic [7:0] rgb_to_luma(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'(LUMA_R) * {8'd0, r} + 16'(LUMA_G) * {8'd0, g} + 16'(LUMA_B) * {8'd0, b};
    return acc[15:8];
  endfunction

endpackage

// File: rtl/gray_frame_ram.sv
// Simple dual-port luma frame store: one write port, one synchronous read port.
// There is no reset, so the array maps onto block RAM.
module gray_frame_ram #(
  parameter int unsigned DEPTH  = 784,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/jpeg_pixel_framer.sv
// Collects decoder pixels in any order into a luma frame buffer, then streams the frame out in raster order.
// Both ports transfer a beat on a rising edge where valid and accept/ready are both high; valid never waits for ready.
module jpeg_pixel_framer
  import jpeg_pkg::*;
#(
  parameter int unsigned MAX_W = 28,
  parameter int unsigned MAX_H = 28,
  parameter int unsigned CRD_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pixel_valid_i,
  output logic             pixel_accept_o,
  input  logic [CRD_W-1:0] width_i,
  input  logic [CRD_W-1:0] height_i,
  input  logic [CRD_W-1:0] pixel_x_i,
  input  logic [CRD_W-1:0] pixel_y_i,
  input  logic [7:0]       pixel_r_i,
  input  logic [7:0]       pixel_g_i,
  input  logic [7:0]       pixel_b_i,
  output logic             frame_valid_o,
  input  logic             frame_ready_i,
  output logic [7:0]       frame_data_o,
  output logic             frame_last_o,
  output logic             oversize_o,
  output framer_state_e    state_o
);

  localparam int unsigned DEPTH  = MAX_W * MAX_H;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CRD_W-1:0] MAX_W_C = CRD_W'(MAX_W);
  localparam logic [CRD_W-1:0] MAX_H_C = CRD_W'(MAX_H);
  localparam logic [CRD_W-1:0] ONE_C   = CRD_W'(1);

  framer_state_e    state_q, state_d;
  logic             accept_q, accept_d;
  logic             started_q, started_d;
  logic [CRD_W-1:0] eff_w_q, eff_w_d, eff_h_q, eff_h_d;
  logic [CNT_W-1:0] target_q, target_d, count_q, count_d;
  logic             oversize_q, oversize_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       luma_q, luma_d;
  logic [CRD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic             rd_done_q, rd_done_d;
  logic             rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic [7:0]       skid_data_q, skid_data_d;

  logic [CRD_W-1:0]  cur_w, cur_h;
  logic [CNT_W-1:0]  cur_target, cnt_next;
  logic              pix_acc, in_rng, fill_done, pop, rd_en, rd_is_last;
  logic [1:0]        occ;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  gray_frame_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (wr_en_q),
    .wr_addr_i(wr_addr_q),
    .wr_data_i(luma_q),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  always_comb begin
    // Dimensions come straight from the ports until the first pixel latches them.
    cur_w      = started_q ? eff_w_q : ((width_i > MAX_W_C) ? MAX_W_C : width_i);
    cur_h      = started_q ? eff_h_q : ((height_i > MAX_H_C) ? MAX_H_C : height_i);
    cur_target = started_q ? target_q : CNT_W'(cur_w * cur_h);
    pix_acc    = pixel_valid_i && accept_q;
    in_rng     = (pixel_x_i < cur_w) && (pixel_y_i < cur_h);
    cnt_next   = count_q + CNT_W'(wr_en_q);
    fill_done  = (state_q == FILL) && wr_en_q && (cnt_next == target_q);
    pop        = out_valid_q && frame_ready_i;
    occ        = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_vld_q) - 2'(pop);
    rd_addr    = ADDR_W'(rd_y_q * MAX_W_C + rd_x_q);
    rd_is_last = (rd_x_q == eff_w_q - ONE_C) && (rd_y_q == eff_h_q - ONE_C);

    state_d      = state_q;
    accept_d     = accept_q;
    started_d    = started_q;
    eff_w_d      = eff_w_q;
    eff_h_d      = eff_h_q;
    target_d     = target_q;
    count_d      = count_q;
    oversize_d   = oversize_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    luma_d       = luma_q;
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    rd_done_d    = rd_done_q;
    rd_vld_d     = 1'b0;
    rd_last_d    = 1'b0;
    rd_en        = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;

    // Output register is the queue head; the skid slot catches the read already in flight on a stall.
    if (pop || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = rd_vld_q;
        skid_data_d  = rd_data;
        skid_last_d  = rd_last_q;
      end else begin
        out_valid_d = rd_vld_q;
        out_data_d  = rd_vld_q ? rd_data : out_data_q;
        out_last_d  = rd_vld_q && rd_last_q;
      end
    end else if (rd_vld_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rd_data;
      skid_last_d  = rd_last_q;
    end

    case (state_q)
      FILL: begin
        if (pix_acc) begin
          if (!started_q) begin
            started_d = 1'b1;
            eff_w_d   = cur_w;
            eff_h_d   = cur_h;
            target_d  = cur_target;
          end
          oversize_d = oversize_q || (width_i > MAX_W_C) || (height_i > MAX_H_C);
          if (in_rng) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(pixel_y_i * MAX_W_C + pixel_x_i);
            luma_d    = rgb_to_luma(pixel_r_i, pixel_g_i, pixel_b_i);
          end
        end
        count_d = cnt_next;
        // Drop accept as soon as the completing pixel is taken so nothing slips into the drain.
        accept_d = !fill_done && !(pix_acc && in_rng && (cnt_next + CNT_W'(1) == cur_target));
        if (fill_done) state_d = DRAIN;
      end
      DRAIN: begin
        accept_d = 1'b0;
        if (!rd_done_q && (occ < 2'd2)) begin
          rd_en     = 1'b1;
          rd_vld_d  = 1'b1;
          rd_last_d = rd_is_last;
          if (rd_is_last) rd_done_d = 1'b1;
          if (rd_x_q == eff_w_q - ONE_C) begin
            rd_x_d = '0;
            rd_y_d = rd_y_q + ONE_C;
          end else begin
            rd_x_d = rd_x_q + ONE_C;
          end
        end
        if (pop && out_last_q) begin
          state_d    = FILL;
          accept_d   = 1'b1;
          started_d  = 1'b0;
          count_d    = '0;
          oversize_d = 1'b0;
          rd_x_d     = '0;
          rd_y_d     = '0;
          rd_done_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FILL;
      accept_q     <= 1'b0;
      started_q    <= 1'b0;
      eff_w_q      <= '0;
      eff_h_q      <= '0;
      target_q     <= '0;
      count_q      <= '0;
      oversize_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      luma_q       <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      rd_done_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      accept_q     <= accept_d;
      started_q    <= started_d;
      eff_w_q      <= eff_w_d;
      eff_h_q      <= eff_h_d;
      target_q     <= target_d;
      count_q      <= count_d;
      oversize_q   <= oversize_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      luma_q       <= luma_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      rd_done_q    <= rd_done_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign pixel_accept_o = accept_q;
  assign frame_valid_o  = out_valid_q;
  assign frame_data_o   = out_data_q;
  assign frame_last_o   = out_last_q;
  assign oversize_o     = oversize_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_jpeg_pixel_framer.sv
// Randomized bench for jpeg_pixel_framer: frames in several pixel orders, output stalls,
// an oversize frame and a mid-drain reset, checked against a frame-level luma model.
module tb_jpeg_pixel_framer;
  import jpeg_pkg::*;

  localparam int MAX_W = 28;
  localparam int MAX_H = 28;
  localparam int CRD_W = 16;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic             clk_i;
  logic             rst_ni;
  logic             pixel_valid_i;
  logic             pixel_accept_o;
  logic [CRD_W-1:0] width_i, height_i, pixel_x_i, pixel_y_i;
  logic [7:0]       pixel_r_i, pixel_g_i, pixel_b_i;
  logic             frame_valid_o;
  logic             frame_ready_i;
  logic [7:0]       frame_data_o;
  logic             frame_last_o;
  logic             oversize_o;
  framer_state_e    state_o;

  pix_t       pq[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  jpeg_pixel_framer #(.MAX_W(MAX_W), .MAX_H(MAX_H), .CRD_W(CRD_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pixel_valid_i (pixel_valid_i),
    .pixel_accept_o(pixel_accept_o),
    .width_i       (width_i),
    .height_i      (height_i),
    .pixel_x_i     (pixel_x_i),
    .pixel_y_i     (pixel_y_i),
    .pixel_r_i     (pixel_r_i),
    .pixel_g_i     (pixel_g_i),
    .pixel_b_i     (pixel_b_i),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .frame_data_o  (frame_data_o),
    .frame_last_o  (frame_last_o),
    .oversize_o    (oversize_o),
    .state_o       (state_o)
  );

  // clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [7:0] ref_luma(input int r, input int g, input int b);
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  function automatic pix_t mk_pix(input int x, input int y, input int vmode);
    pix_t p;
    p.x = x;
    p.y = y;
    if (vmode == 0) begin
      p.r = 8'((x + y) & 255);
      p.g = p.r;
      p.b = p.r;
    end else begin
      p.r = 8'($urandom_range(0, 255));
      p.g = 8'($urandom_range(0, 255));
      p.b = 8'($urandom_range(0, 255));
    end
    return p;
  endfunction

  // order 0: raster, 1: 8x8 blocks, 2: clipped pixels first then in-frame pixels shuffled
  task automatic gen_frame(input int w, input int h, input int order, input int vmode);
    pix_t in_q[$];
    pix_t drop_q[$];
    pix_t t;
    pq.delete();
    if (order == 1) begin
      for (int by = 0; by < h; by += 8)
        for (int bx = 0; bx < w; bx += 8)
          for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
              pq.push_back(mk_pix(bx + x, by + y, vmode));
    end else begin
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          if (order == 2 && (x >= MAX_W || y >= MAX_H)) drop_q.push_back(mk_pix(x, y, vmode));
          else in_q.push_back(mk_pix(x, y, vmode));
        end
      if (order == 2)
        for (int i = in_q.size() - 1; i > 0; i--) begin
          int j;
          j = $urandom_range(i, 0);
          t = in_q[i];
          in_q[i] = in_q[j];
          in_q[j] = t;
        end
      foreach (drop_q[i]) pq.push_back(drop_q[i]);
      foreach (in_q[i]) pq.push_back(in_q[i]);
    end
  endtask

  task automatic build_expect(input int w, input int h);
    int ew, eh;
    logic [7:0] img [MAX_H][MAX_W];
    ew = (w > MAX_W) ? MAX_W : w;
    eh = (h > MAX_H) ? MAX_H : h;
    foreach (pq[i])
      if (pq[i].x < ew && pq[i].y < eh)
        img[pq[i].y][pq[i].x] = ref_luma(int'(pq[i].r), int'(pq[i].g), int'(pq[i].b));
    for (int y = 0; y < eh; y++)
      for (int x = 0; x < ew; x++)
        exp_q.push_back(img[y][x]);
  endtask

  // driver tasks
  task automatic send_pixel(input pix_t p, input int w, input int h);
    int n = 0;
    @(negedge clk_i);
    pixel_valid_i = 1'b1;
    width_i       = CRD_W'(w);
    height_i      = CRD_W'(h);
    pixel_x_i     = CRD_W'(p.x);
    pixel_y_i     = CRD_W'(p.y);
    pixel_r_i     = p.r;
    pixel_g_i     = p.g;
    pixel_b_i     = p.b;
    while (!pixel_accept_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check_val("accept_timeout", 32'(pixel_accept_o), 1);
  endtask

  task automatic send_frame(input int w, input int h);
    foreach (pq[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk_i);
        pixel_valid_i = 1'b0;
      end
      send_pixel(pq[i], w, h);
    end
    @(negedge clk_i);
    pixel_valid_i = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles each cycle, 2: random stalls
  task automatic drain_frame(input int mode, input logic exp_ov);
    int         cyc = 0;
    logic       stalled = 1'b0;
    logic [7:0] held_d = '0;
    logic       held_l = 1'b0;
    logic [7:0] e;
    check_val("oversize_in_drain", 32'(oversize_o), 32'(exp_ov));
    while (exp_q.size() > 0 && cyc < 6000) begin
      @(negedge clk_i);
      cyc++;
      case (mode)
        0:       frame_ready_i = 1'b1;
        1:       frame_ready_i = cyc[0];
        default: frame_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      check_val("accept_in_drain", 32'(pixel_accept_o), 0);
      if (stalled) begin
        check_val("hold_valid", 32'(frame_valid_o), 1);
        check_val("hold_data", 32'(frame_data_o), 32'(held_d));
        check_val("hold_last", 32'(frame_last_o), 32'(held_l));
      end
      stalled = frame_valid_o && !frame_ready_i;
      held_d  = frame_data_o;
      held_l  = frame_last_o;
      if (frame_valid_o && frame_ready_i) begin
        e = exp_q.pop_front();
        check_val("data", 32'(frame_data_o), 32'(e));
        check_val("last", 32'(frame_last_o), 32'(exp_q.size() == 0));
      end
    end
    if (exp_q.size() != 0) check_val("drain_timeout", 32'(exp_q.size()), 0);
    @(negedge clk_i);
    frame_ready_i = 1'b0;
    check_val("valid_after_last", 32'(frame_valid_o), 0);
    check_val("oversize_cleared", 32'(oversize_o), 0);
    check_val("accept_after_last", 32'(pixel_accept_o), 1);
    check_val("state_after_last", 32'(state_o), 32'(FILL));
  endtask

  task automatic run_frame(input int w, input int h, input int order, input int vmode,
                           input int dmode);
    gen_frame(w, h, order, vmode);
    exp_q.delete();
    build_expect(w, h);
    send_frame(w, h);
    drain_frame(dmode, (w > MAX_W) || (h > MAX_H));
  endtask

  initial begin
    rst_ni        = 1'b1;
    pixel_valid_i = 1'b0;
    frame_ready_i = 1'b0;
    width_i       = '0;
    height_i      = '0;
    pixel_x_i     = '0;
    pixel_y_i     = '0;
    pixel_r_i     = '0;
    pixel_g_i     = '0;
    pixel_b_i     = '0;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("rst_accept", 32'(pixel_accept_o), 0);
    check_val("rst_valid", 32'(frame_valid_o), 0);
    check_val("rst_data", 32'(frame_data_o), 0);
    check_val("rst_last", 32'(frame_last_o), 0);
    check_val("rst_oversize", 32'(oversize_o), 0);
    check_val("rst_state", 32'(state_o), 32'(FILL));
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("accept_after_rst", 32'(pixel_accept_o), 1);

    run_frame(28, 28, 0, 0, 0);
    run_frame(16, 16, 1, 1, 0);

    pq.delete();
    pq.push_back('{x: 0, y: 0, r: 8'd255, g: 8'd0,   b: 8'd0});
    pq.push_back('{x: 1, y: 0, r: 8'd0,   g: 8'd0,   b: 8'd255});
    pq.push_back('{x: 0, y: 1, r: 8'd255, g: 8'd255, b: 8'd255});
    pq.push_back('{x: 1, y: 1, r: 8'd0,   g: 8'd255, b: 8'd0});
    exp_q.delete();
    exp_q.push_back(8'd76);
    exp_q.push_back(8'd28);
    exp_q.push_back(8'd255);
    exp_q.push_back(8'd149);
    send_frame(2, 2);
    drain_frame(0, 1'b0);

    run_frame(28, 28, 2, 1, 1);
    run_frame(20, 12, 2, 1, 2);
    run_frame(32, 32, 2, 1, 2);

    gen_frame(10, 10, 2, 1);
    exp_q.delete();
    build_expect(10, 10);
    send_frame(10, 10);
    repeat (8) begin
      @(negedge clk_i);
      frame_ready_i = 1'b1;
    end
    check_val("mid_drain_state", 32'(state_o), 32'(DRAIN));
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_val("abort_valid", 32'(frame_valid_o), 0);
    check_val("abort_data", 32'(frame_data_o), 0);
    check_val("abort_last", 32'(frame_last_o), 0);
    check_val("abort_accept", 32'(pixel_accept_o), 0);
    check_val("abort_state", 32'(state_o), 32'(FILL));
    exp_q.delete();
    frame_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("accept_after_abort", 32'(pixel_accept_o), 1);
    run_frame(28, 28, 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
